// File: rtl/instr_sequencer.sv
// Instruction sequencer: a circular instruction queue fed by the host, drained
// one word at a time into a downstream ALU datapath with a START/RDY handshake.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | waiting for a queued instruction while the datapath is ready
//   ISSUE     | Instr is loaded; START pulses for this single cycle
//   WAIT_BUSY | waiting for the datapath to drop RDY, or for the timeout
//   WAIT_DONE | datapath busy; completion is RDY returning high
module instr_sequencer #(
  parameter int DEPTH        = 8,
  parameter int WAIT_TIMEOUT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WrEn,
  input  logic [15:0] WrData,
  input  logic        Flush,
  output logic        Full,
  output logic        Empty,
  output logic [15:0] Instr,
  output logic        START,
  input  logic        RDY,
  output logic        Busy,
  output logic [7:0]  Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int TMR_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WAIT_TIMEOUT - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state;
  state_t nextState;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [OCC_W-1:0] occupancy;
  logic [TMR_W-1:0] timer;

  logic wrAccept;
  logic popReq;
  logic complete;

  // Full/Empty decode only the registered occupancy, so a same-cycle pop
  // never opens room for a write that arrives while the queue is full.
  assign Full     = (occupancy == OCC_FULL);
  assign Empty    = (occupancy == '0);
  assign wrAccept = WrEn && !Full;

  // START and Busy come straight from the state register; RDY only affects
  // the next state, never these outputs in the same cycle.
  assign START = (state == ISSUE);
  assign Busy  = (state != IDLE);

  // Queue storage; entries need no reset because the pointers define validity.
  always_ff @(posedge CLK) begin
    if (wrAccept && !Flush) begin
      mem[wrPtr] <= WrData;
    end
  end

  // Pointers and occupancy; Flush overrides any same-cycle write or pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else if (Flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (wrAccept) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popReq) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({wrAccept, popReq})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode plus the pop and completion strobes.
  always_comb begin
    nextState = state;
    popReq    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        // A flush in the same cycle empties the queue, so nothing is popped.
        if (!Empty && RDY && !Flush) begin
          popReq    = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        nextState = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!RDY) begin
          nextState = WAIT_DONE;
        end else if (timer == '0) begin
          complete  = 1'b1;
          nextState = IDLE;
        end
      end
      WAIT_DONE: begin
        if (RDY) begin
          complete  = 1'b1;
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Timeout down-counter: loaded during ISSUE, counts consecutive RDY-high
  // cycles in WAIT_BUSY; terminal count at zero marks completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= TMR_LOAD;
    end else if ((state == WAIT_BUSY) && RDY && (timer != '0)) begin
      timer <= timer - TMR_W'(1);
    end
  end

  // Instruction register holds the popped word until the next pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Instr <= 16'h0000;
    end else if (popReq) begin
      Instr <= mem[rdPtr];
    end
  end

  // Completion counter, wraps naturally at 8 bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Count <= 8'd0;
    end else if (complete) begin
      Count <= Count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a scoreboard queue receives every
// word the host expects to be accepted and is popped on each observed START.
module tb_instr_sequencer;

  logic        CLK;
  logic        RST;
  logic        WrEn;
  logic [15:0] WrData;
  logic        Flush;
  logic        Full;
  logic        Empty;
  logic [15:0] Instr;
  logic        START;
  logic        RDY;
  logic        Busy;
  logic [7:0]  Count;

  int          checks    = 0;
  int          failures  = 0;
  int          startCount = 0;
  logic [15:0] sbq [$];
  logic [15:0] monExp;

  instr_sequencer #(.DEPTH(8), .WAIT_TIMEOUT(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .WrEn   (WrEn),
    .WrData (WrData),
    .Flush  (Flush),
    .Full   (Full),
    .Empty  (Empty),
    .Instr  (Instr),
    .START  (START),
    .RDY    (RDY),
    .Busy   (Busy),
    .Count  (Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard: every START must present the oldest expected word.
  always @(negedge CLK) begin
    if (!RST && START) begin
      startCount++;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_start Instr=%h expected no START", Instr);
      end else begin
        monExp = sbq.pop_front();
        if (Instr !== monExp) begin
          failures++;
          $display("FAIL fifo_order Instr=%h expected=%h", Instr, monExp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic do_reset();
    WrEn = 1'b0; WrData = 16'h0; Flush = 1'b0; RDY = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    sbq.delete();
    startCount = 0;
    @(negedge CLK);
  endtask

  task automatic write_word(input logic [15:0] w, input bit accept);
    @(negedge CLK);
    WrEn = 1'b1;
    WrData = w;
    if (accept) sbq.push_back(w);
    @(negedge CLK);
    WrEn = 1'b0;
  endtask

  task automatic wait_start(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (START) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s START not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_drain(input int target, input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (startCount >= target && !Busy && Empty) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s drain timeout starts=%0d expected=%0d Busy=%b Empty=%b",
               name, startCount, target, Busy, Empty);
    end
  endtask

  task automatic test_reset();
    WrEn = 1'b0; WrData = 16'h0; Flush = 1'b0; RDY = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    checks += 6;
    if (Busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    if (START !== 1'b0)      begin failures++; $display("FAIL reset_start got=%b exp=0", START); end
    if (Full !== 1'b0)       begin failures++; $display("FAIL reset_full got=%b exp=0", Full); end
    if (Empty !== 1'b1)      begin failures++; $display("FAIL reset_empty got=%b exp=1", Empty); end
    if (Count !== 8'd0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
    if (Instr !== 16'h0000)  begin failures++; $display("FAIL reset_instr got=%h exp=0000", Instr); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    do_reset();
    RDY = 1'b1;
    write_word(16'h1234, 1);
    wait_start(10, "single_start");
    RDY = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (Busy !== 1'b1) begin failures++; $display("FAIL single_busy_held got=%b exp=1", Busy); end
    RDY = 1'b1;
    wait_drain(1, 10, "single");
    checks += 3;
    if (Count !== 8'd1)     begin failures++; $display("FAIL single_count got=%0d exp=1", Count); end
    if (Instr !== 16'h1234) begin failures++; $display("FAIL single_instr got=%h exp=1234", Instr); end
    if (startCount !== 1)   begin failures++; $display("FAIL single_starts got=%0d exp=1", startCount); end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    RDY = 1'b1;
    sbq.push_back(16'h7E57);
    WrEn = 1'b1;
    WrData = 16'h7E57;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      WrEn = 1'b0;
      n++;
      if (START) break;
    end
    checks++;
    if (n !== 2) begin failures++; $display("FAIL timeout_start_latency got=%0d exp=2", n); end
    repeat (4) @(negedge CLK);
    checks += 2;
    if (Count !== 8'd0) begin failures++; $display("FAIL timeout_early_count got=%0d exp=0", Count); end
    if (Busy !== 1'b1)  begin failures++; $display("FAIL timeout_early_busy got=%b exp=1", Busy); end
    @(negedge CLK);
    checks += 2;
    if (Count !== 8'd1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", Count); end
    if (Busy !== 1'b0)  begin failures++; $display("FAIL timeout_busy got=%b exp=0", Busy); end
  endtask

  task automatic test_full();
    do_reset();
    RDY = 1'b0;
    for (int i = 0; i < 9; i++) begin
      write_word(16'hA000 + 16'(i), i < 8);
      if (i == 6) begin
        checks++;
        if (Full !== 1'b0) begin failures++; $display("FAIL full_at_7 got=%b exp=0", Full); end
      end
    end
    checks += 2;
    if (Full !== 1'b1)  begin failures++; $display("FAIL full_at_8 got=%b exp=1", Full); end
    if (Empty !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", Empty); end
    RDY = 1'b1;
    wait_drain(8, 200, "full");
    repeat (10) @(negedge CLK);
    checks += 4;
    if (startCount !== 8)  begin failures++; $display("FAIL full_starts got=%0d exp=8", startCount); end
    if (Count !== 8'd8)    begin failures++; $display("FAIL full_count got=%0d exp=8", Count); end
    if (Empty !== 1'b1)    begin failures++; $display("FAIL full_drained got=%b exp=1", Empty); end
    if (sbq.size() !== 0)  begin failures++; $display("FAIL full_sb_left got=%0d exp=0", sbq.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    RDY = 1'b0;
    for (int i = 0; i < 3; i++) write_word(16'hB000 + 16'(i), 1);
    RDY = 1'b1;
    wait_start(10, "flush_start");
    RDY = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (Busy !== 1'b1) begin failures++; $display("FAIL flush_in_wait got=%b exp=1", Busy); end
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    sbq.delete();
    checks += 2;
    if (Empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", Empty); end
    if (Busy !== 1'b1)  begin failures++; $display("FAIL flush_kept_inflight got=%b exp=1", Busy); end
    RDY = 1'b1;
    repeat (15) @(negedge CLK);
    checks += 4;
    if (Count !== 8'd1)   begin failures++; $display("FAIL flush_count got=%0d exp=1", Count); end
    if (startCount !== 1) begin failures++; $display("FAIL flush_starts got=%0d exp=1", startCount); end
    if (Empty !== 1'b1)   begin failures++; $display("FAIL flush_empty_end got=%b exp=1", Empty); end
    if (Busy !== 1'b0)    begin failures++; $display("FAIL flush_idle got=%b exp=0", Busy); end
  endtask

  task automatic test_reset_midflight();
    int base;
    do_reset();
    RDY = 1'b1;
    write_word(16'hC000, 1);
    wait_drain(1, 30, "midrst_pre");
    RDY = 1'b0;
    for (int i = 1; i < 4; i++) write_word(16'hC000 + 16'(i), 1);
    RDY = 1'b1;
    wait_start(10, "midrst_start");
    RDY = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (Count !== 8'd1) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=1", Count); end
    #2 RST = 1'b1;
    #1;
    checks += 5;
    if (Count !== 8'd0)     begin failures++; $display("FAIL midrst_count got=%0d exp=0", Count); end
    if (Empty !== 1'b1)     begin failures++; $display("FAIL midrst_empty got=%b exp=1", Empty); end
    if (START !== 1'b0)     begin failures++; $display("FAIL midrst_start got=%b exp=0", START); end
    if (Busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy got=%b exp=0", Busy); end
    if (Instr !== 16'h0000) begin failures++; $display("FAIL midrst_instr got=%h exp=0000", Instr); end
    sbq.delete();
    base = startCount;
    @(negedge CLK);
    RST = 1'b0;
    RDY = 1'b1;
    repeat (12) @(negedge CLK);
    checks += 2;
    if (startCount !== base) begin failures++; $display("FAIL midrst_no_start got=%0d exp=%0d", startCount, base); end
    if (Count !== 8'd0)      begin failures++; $display("FAIL midrst_count_after got=%0d exp=0", Count); end
  endtask

  task automatic test_wrap();
    do_reset();
    RDY = 1'b1;
    for (int i = 0; i < 256; i++) begin
      write_word(16'(i) ^ 16'h5A5A, 1);
      wait_drain(i + 1, 30, "wrap");
      if (i == 254) begin
        checks++;
        if (Count !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", Count); end
      end
    end
    checks++;
    if (Count !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", Count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    RDY = 1'b0;
    for (int i = 0; i < 4; i++) write_word(16'hD000 + 16'(i), 1);
    // write and pop land on the same edge at occupancy 4
    WrEn = 1'b1;
    WrData = 16'hD004;
    sbq.push_back(16'hD004);
    RDY = 1'b1;
    @(negedge CLK);
    WrEn = 1'b0;
    RDY = 1'b0;
    for (int i = 5; i < 8; i++) write_word(16'hD000 + 16'(i), 1);
    checks++;
    if (Full !== 1'b0) begin failures++; $display("FAIL simul_occ7 got=%b exp=0", Full); end
    write_word(16'hD008, 1);
    checks++;
    if (Full !== 1'b1) begin failures++; $display("FAIL simul_occ8 got=%b exp=1", Full); end
    write_word(16'hD009, 0);
    RDY = 1'b1;
    wait_drain(9, 200, "simul");
    repeat (10) @(negedge CLK);
    checks += 3;
    if (startCount !== 9) begin failures++; $display("FAIL simul_starts got=%0d exp=9", startCount); end
    if (Count !== 8'd9)   begin failures++; $display("FAIL simul_count got=%0d exp=9", Count); end
    if (sbq.size() !== 0) begin failures++; $display("FAIL simul_sb_left got=%0d exp=0", sbq.size()); end
  endtask

  initial begin
    RST = 1'b1; WrEn = 1'b0; WrData = 16'h0; Flush = 1'b0; RDY = 1'b0;
    test_reset();
    test_single();
    test_timeout();
    test_full();
    test_flush();
    test_reset_midflight();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: DEPTH, 8, number of instruction queue entries (power of two, 2..16).
REQ-002 Parameter: WAIT_TIMEOUT, 4, cycles RDY may stay high after START before the instruction is treated as complete.
REQ-003 Port: CLK  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous and active-high.
REQ-005 Port: WrEn  input  1  host write strobe; pushes WrData into the queue.
REQ-006 Port: WrData  input  16  instruction word to enqueue.
REQ-007 Port: Flush  input  1  synchronous queue clear.
REQ-008 Port: Full  output  1  queue holds DEPTH entries.
REQ-009 Port: Empty  output  1  queue holds 0 entries.
REQ-010 Port: Instr  output  16  instruction presented to the downstream ALU datapath.
REQ-011 Port: START  output  1  one-cycle pulse launching Instr downstream.
REQ-012 Port: RDY  input  1  downstream ready; high = ALU datapath idle/done.
REQ-013 Port: Busy  output  1  high whenever the state machine is not IDLE.
REQ-014 Port: Count  output  8  number of completed instructions, modulo 256.

Function
REQ-015 Queue SHALL be a circular buffer with read/write pointers wrapping DEPTH-1 -> 0 and an occupancy counter 0..DEPTH; Full and Empty SHALL be decoded from the registered occupancy.
REQ-016 A write SHALL be accepted only when WrEn=1 and Full=0; a write while Full=1 SHALL be dropped with no state change, even if a pop occurs in the same cycle.
REQ-017 Simultaneous accepted write and pop SHALL leave occupancy unchanged and advance both pointers.
REQ-018 Flush=1 SHALL zero both pointers and occupancy on the next edge, take priority over a same-cycle write and pop, and SHALL NOT abort an instruction already issued.
REQ-019 State machine SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE: when Empty=0 and RDY=1, the head entry SHALL be popped into the Instr register and the state SHALL go to ISSUE; otherwise stay IDLE.
REQ-021 ISSUE: START SHALL be 1 for exactly this one cycle; next state WAIT_BUSY.
REQ-022 WAIT_BUSY: RDY=0 SHALL move to WAIT_DONE; if RDY remains 1 for WAIT_TIMEOUT consecutive cycles, the instruction SHALL count as complete and the state SHALL return to IDLE.
REQ-023 WAIT_DONE: RDY=1 SHALL increment Count and return to IDLE; RDY=0 stays.
REQ-024 Count SHALL increment by exactly 1 per completed instruction (both REQ-022 timeout and REQ-023 paths) and wrap 255 -> 0.
REQ-025 Instr SHALL remain stable from the pop cycle until the next pop; minimum issue spacing SHALL be 4 cycles (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE/IDLE).
REQ-026 Instructions SHALL be issued in strict FIFO order, with none lost or duplicated except by Flush or full-queue drop.
REQ-027 All outputs SHALL be driven from registers or from the registered state only, with no combinational path from RDY to START.

Reset
REQ-028 RST=1 SHALL asynchronously force state IDLE, pointers, occupancy and Count to 0, Instr to 16'h0000, START=0, Busy=0, Full=0 and Empty=1.
REQ-029 RST asserted mid-instruction SHALL discard the queue and the in-flight instruction with no Count increment; operation SHALL resume from IDLE on the first edge after release.

Verification
REQ-030 Write 16'h1234 with RDY=1; model RDY low for 3 cycles after START -> one START pulse, Instr=16'h1234, Count=1, Busy falls after RDY returns high.
REQ-031 Write 9 words with RDY=0 held -> first 8 accepted, Full=1 and the 9th dropped; then release RDY -> exactly 8 STARTs in write order, Count=8, Empty=1.
REQ-032 Hold RDY=1 permanently after 1 write -> START at cycle 2, completion via timeout after 4 cycles, Count=1.
REQ-033 Queue 3 entries, assert Flush during WAIT_DONE of the first -> first instruction completes (Count=1), no further START, Empty=1.
REQ-034 Assert RST in WAIT_DONE with 2 entries queued -> Count=0, Empty=1, START=0 immediately, with no START after release.
REQ-035 Run 256 completions -> Count wraps to 0; simultaneous write+pop at occupancy 4 -> occupancy stays 4.
